multicycle_control: RTL

- Main control FSM for the multicycle 16-bit CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select. Generates the 2-bit alu_op consumed by the ALU control unit; IR func bits go straight from the datapath to that unit.
- Handshakes with the unified instruction/data memory through mem_ready, so wait states are supported.

---
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle 16-bit CPU
// Moore outputs are registered from the next state; only mem_ready/opcode-qualified strobes are combinational.
module multicycle_control #(
  parameter int OP_W         = 4,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic [1:0]      alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_ne,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            retire,
  output logic            halted,
  output logic [3:0]      state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_ALU_WB_R = 4'd8,
    S_EXEC_I   = 4'd9,
    S_ALU_WB_I = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic       halted;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(6);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   op_illegal;

  assign op_illegal = (opcode > OP_JMP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:          state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_JMP:        state_d = S_JUMP;
          default:       state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_d = S_ALU_WB_R;
      S_ALU_WB_R: state_d = S_FETCH;
      S_EXEC_I:   state_d = S_ALU_WB_I;
      S_ALU_WB_I: state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  // Decode the state being entered so the registered outputs line up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
      end
      S_DECODE:   ctrl_d.alu_src_b = 2'b11;
      S_MEM_ADDR, S_EXEC_I: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b10;
      end
      S_ALU_WB_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.retire    = 1'b1;
      end
      S_ALU_WB_I: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_src        = 2'b01;
        ctrl_d.branch_ne     = (opcode == OP_BNE);
        ctrl_d.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = 2'b10;
        ctrl_d.retire   = 1'b1;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_op        = ctrl_q.alu_op;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign pc_src        = ctrl_q.pc_src;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign branch_ne     = ctrl_q.branch_ne;
  assign iord          = ctrl_q.iord;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign halted        = ctrl_q.halted;
  assign state_dbg     = state_q;

  assign ir_write = (state_q == S_FETCH) && mem_ready;
  assign pc_write = ctrl_q.pc_write || ((state_q == S_FETCH) && mem_ready);
  assign retire   = ctrl_q.retire
                 || ((state_q == S_MEM_WR) && mem_ready)
                 || ((state_q == S_DECODE) && op_illegal && !ILLEGAL_HALT);

endmodule
